// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - MEM stage types: pipe bundles, dbus structs, size masks
package memory_access_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [3:0] {
    OP_ALU, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } decode_op_t;

  typedef struct packed {
    decode_op_t op;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
    logic [63:0] result;
    logic [63:0] memdata;
    control_t    ctl;
    logic [4:0]  dst;
  } execute_data_t;

  typedef struct packed {
    logic regwrite;
  } mem_ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
    logic [63:0] result;
    mem_ctl_t    ctl;
    logic [4:0]  dst;
    logic        misalign;
  } memory_data_t;

  typedef enum logic {IDLE, BUSY} mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic msize_t op_size(decode_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MSIZE1;
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      default:              return MSIZE8;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return MASK_B;
      MSIZE2:  return MASK_H;
      MSIZE4:  return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  function automatic logic is_aligned(msize_t s, logic [2:0] a);
    case (s)
      MSIZE1:  return 1'b1;
      MSIZE2:  return a[0] == 1'b0;
      MSIZE4:  return a[1:0] == 2'b00;
      default: return a == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - EX->MEM->WB handshake and data bus bundle
interface memory_access_if;
  import memory_access_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          flush;
  execute_data_t dataE;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          out_valid;
  logic          out_ready;
  memory_data_t  dataM;

  modport slave (
    input  in_valid, flush, dataE, dresp, out_ready,
    output in_ready, dreq, out_valid, dataM
  );

  modport master (
    output in_valid, flush, dataE, dresp, out_ready,
    input  in_ready, dreq, out_valid, dataM
  );
endinterface

// File: rtl/memory_access_mem_align.sv
// rtl/memory_access_mem_align.sv - byte-lane placement for stores, extract/extend for loads
module mem_align
  import memory_access_pkg::*;
(
  input  decode_op_t  op,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata_raw,
  input  logic [63:0] rdata,
  output msize_t      size,
  output logic        aligned,
  output logic [7:0]  strobe,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic        is_store;
  logic [5:0]  shift;
  logic [63:0] shifted;

  always_comb begin
    is_store = op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    size     = op_size(op);
    aligned  = is_aligned(size, addr_lo);
    shift    = {addr_lo, 3'b000};
    strobe   = is_store ? (size_mask(size) << addr_lo) : 8'h00;
    wdata    = is_store ? (wdata_raw << shift) : 64'h0;
    shifted  = rdata >> shift;
    case (op)
      OP_LB:   load_data = {{56{shifted[7]}}, shifted[7:0]};
      OP_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
      OP_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
      OP_LBU:  load_data = {56'h0, shifted[7:0]};
      OP_LHU:  load_data = {48'h0, shifted[15:0]};
      OP_LWU:  load_data = {32'h0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: 1-cycle ALU pass-through, dbus loads/stores with stall
module memory_access
  import memory_access_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  memory_access_if.slave  bus
);

  mem_state_t   state;
  dbus_req_t    req_q;
  logic         kill_q;
  logic         out_valid_q;
  memory_data_t data_m_q;

  logic [63:0]  lat_pc;
  logic [31:0]  lat_instr;
  decode_op_t   lat_op;
  logic         lat_load;
  logic         lat_regwrite;
  logic [4:0]   lat_dst;

  decode_op_t   al_op;
  logic [2:0]   al_lo;
  msize_t       al_size;
  logic         al_aligned;
  logic [7:0]   al_strobe;
  logic [63:0]  al_wdata;
  logic [63:0]  al_load;

  logic         accept;
  logic         is_mem_e;
  logic         misaligned_e;

  // One aligner serves both directions: incoming bundle in IDLE, latched op in BUSY.
  assign al_op = (state == BUSY) ? lat_op : bus.dataE.ctl.op;
  assign al_lo = (state == BUSY) ? req_q.addr[2:0] : bus.dataE.result[2:0];

  mem_align u_align (
    .op        (al_op),
    .addr_lo   (al_lo),
    .wdata_raw (bus.dataE.memdata),
    .rdata     (bus.dresp.data),
    .size      (al_size),
    .aligned   (al_aligned),
    .strobe    (al_strobe),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.dreq      = req_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dataM     = data_m_q;

  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign is_mem_e     = bus.dataE.ctl.memread || bus.dataE.ctl.memwrite;
  assign misaligned_e = ALIGN_CHECK && !al_aligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_q        <= '0;
      kill_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      data_m_q     <= '0;
      lat_pc       <= '0;
      lat_instr    <= '0;
      lat_op       <= OP_ALU;
      lat_load     <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_dst      <= '0;
    end else begin
      if ((out_valid_q && bus.out_ready) || bus.flush)
        out_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem_e && !misaligned_e) begin
              state        <= BUSY;
              req_q.valid  <= 1'b1;
              req_q.addr   <= bus.dataE.result;
              req_q.size   <= al_size;
              req_q.strobe <= al_strobe;
              req_q.data   <= al_wdata;
              lat_pc       <= bus.dataE.pc;
              lat_instr    <= bus.dataE.instruction;
              lat_op       <= bus.dataE.ctl.op;
              lat_load     <= bus.dataE.ctl.memread;
              lat_regwrite <= bus.dataE.ctl.regwrite;
              lat_dst      <= bus.dataE.dst;
              kill_q       <= 1'b0;
            end else begin
              // Reaching here with a memory op means it was rejected as misaligned.
              out_valid_q              <= 1'b1;
              data_m_q.pc              <= bus.dataE.pc;
              data_m_q.instruction     <= bus.dataE.instruction;
              data_m_q.result          <= bus.dataE.result;
              data_m_q.ctl.regwrite    <= is_mem_e ? 1'b0 : bus.dataE.ctl.regwrite;
              data_m_q.dst             <= bus.dataE.dst;
              data_m_q.misalign        <= is_mem_e;
            end
          end
        end
        BUSY: begin
          if (bus.flush)
            kill_q <= 1'b1;
          if (bus.dresp.data_ok) begin
            state       <= IDLE;
            req_q.valid <= 1'b0;
            kill_q      <= 1'b0;
            if (!kill_q && !bus.flush) begin
              out_valid_q           <= 1'b1;
              data_m_q.pc           <= lat_pc;
              data_m_q.instruction  <= lat_instr;
              data_m_q.result       <= lat_load ? al_load : 64'h0;
              data_m_q.ctl.regwrite <= lat_load ? lat_regwrite : 1'b0;
              data_m_q.dst          <= lat_dst;
              data_m_q.misalign     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard bench for memory_access
module tb_memory_access;
  import memory_access_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_access_if bus ();

  memory_access #(.ALIGN_CHECK(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int dreq_cycles = 0;
  memory_data_t exp_q[$];

  always @(negedge clk) if (bus.dreq.valid) dreq_cycles++;

  always @(negedge clk) begin : monitor
    memory_data_t e;
    if (reset && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got result=%h pc=%h, no output expected",
                 bus.dataM.result, bus.dataM.pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.dataM !== e) begin
          bad++;
          $display("FAIL out_item pc=%h: got res=%h rw=%b dst=%0d mis=%b, exp res=%h rw=%b dst=%0d mis=%b",
                   e.pc, bus.dataM.result, bus.dataM.ctl.regwrite, bus.dataM.dst, bus.dataM.misalign,
                   e.result, e.ctl.regwrite, e.dst, e.misalign);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic execute_data_t mk(input decode_op_t op, input logic [63:0] pc,
                                       input logic [63:0] res, input logic [63:0] md,
                                       input logic [4:0] dst);
    execute_data_t e;
    e = '0;
    e.pc           = pc;
    e.instruction  = pc[31:0] ^ 32'h0000_0013;
    e.result       = res;
    e.memdata      = md;
    e.ctl.op       = op;
    e.ctl.memread  = op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    e.ctl.memwrite = op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    e.ctl.regwrite = !e.ctl.memwrite;
    e.dst          = dst;
    return e;
  endfunction

  function automatic memory_data_t mkm(input execute_data_t e, input logic [63:0] res,
                                       input logic rw, input logic mis);
    memory_data_t m;
    m.pc           = e.pc;
    m.instruction  = e.instruction;
    m.result       = res;
    m.ctl.regwrite = rw;
    m.dst          = e.dst;
    m.misalign     = mis;
    return m;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input execute_data_t e, output int waited);
    waited = 0;
    bus.dataE    = e;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("issue_ready", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic respond(input string tag, input logic [63:0] addr, input msize_t size,
                         input logic [7:0] strobe, input logic is_st, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int delay);
    int n = 0;
    while (!bus.dreq.valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_latency"}, 64'(n), 64'd0);
    check({tag, "_addr"}, bus.dreq.addr, addr);
    check({tag, "_size"}, 64'(bus.dreq.size), 64'(size));
    if (is_st) begin
      check({tag, "_strobe"}, 64'(bus.dreq.strobe), 64'(strobe));
      check({tag, "_wdata"}, bus.dreq.data, wdata);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_stable"},
            {63'h0, bus.dreq.valid && bus.dreq.addr == addr && bus.dreq.strobe == strobe &&
                    (!is_st || bus.dreq.data == wdata) && !bus.in_ready}, 64'h1);
    end
    bus.dresp.data_ok = 1'b1;
    bus.dresp.addr_ok = 1'b1;
    bus.dresp.data    = rdata;
    @(negedge clk);
    bus.dresp = '0;
  endtask

  task automatic load_test(input string tag, input decode_op_t op, input logic [63:0] addr,
                           input msize_t size, input logic [63:0] rdata, input logic [63:0] exp_res);
    execute_data_t e;
    int w;
    e = mk(op, addr + 64'h10000, addr, 64'h0, 5'd7);
    exp_q.push_back(mkm(e, exp_res, 1'b1, 1'b0));
    issue(e, w);
    respond(tag, addr, size, 8'h00, 1'b0, 64'h0, rdata, 3);
    check({tag, "_ret_latency"}, {63'h0, bus.out_valid}, 64'h1);
  endtask

  initial begin
    execute_data_t e;
    int w, d0;

    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.dataE     = '0;
    bus.dresp     = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_dreq_valid", {63'h0, bus.dreq.valid}, 64'h0);
    check("rst_dataM_zero", {63'h0, bus.dataM == '0}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // ALU pass-through, latency 1, no bus activity
    d0 = dreq_cycles;
    e = mk(OP_ALU, 64'h100, 64'h1234, 64'h0, 5'd3);
    exp_q.push_back(mkm(e, 64'h1234, 1'b1, 1'b0));
    issue(e, w);
    check("add_latency", {63'h0, bus.out_valid}, 64'h1);
    @(negedge clk);
    check("add_no_dreq", 64'(dreq_cycles - d0), 64'd0);

    load_test("lb",  OP_LB,  64'h1003, MSIZE1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load_test("lbu", OP_LBU, 64'h1003, MSIZE1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    load_test("lh",  OP_LH,  64'h6006, MSIZE2, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_ABCD);
    load_test("lw",  OP_LW,  64'h5004, MSIZE4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    load_test("lwu", OP_LWU, 64'h5004, MSIZE4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    load_test("ld",  OP_LD,  64'h5008, MSIZE8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Stores: result 0, regwrite 0
    e = mk(OP_SH, 64'h200, 64'h2002, 64'hBEEF, 5'd0);
    exp_q.push_back(mkm(e, 64'h0, 1'b0, 1'b0));
    issue(e, w);
    respond("sh", 64'h2002, MSIZE2, 8'h0C, 1'b1, 64'h0000_0000_BEEF_0000, 64'h0, 3);
    e = mk(OP_SW, 64'h204, 64'h7004, 64'hCAFE_F00D, 5'd0);
    exp_q.push_back(mkm(e, 64'h0, 1'b0, 1'b0));
    issue(e, w);
    respond("sw", 64'h7004, MSIZE4, 8'hF0, 1'b1, 64'hCAFE_F00D_0000_0000, 64'h0, 1);
    e = mk(OP_SD, 64'h208, 64'h7000, 64'h1122_3344_5566_7788, 5'd0);
    exp_q.push_back(mkm(e, 64'h0, 1'b0, 1'b0));
    issue(e, w);
    respond("sd", 64'h7000, MSIZE8, 8'hFF, 1'b1, 64'h1122_3344_5566_7788, 64'h0, 0);

    // Misaligned LW: no bus request, misalign flagged after 1 cycle
    @(negedge clk);
    d0 = dreq_cycles;
    e = mk(OP_LW, 64'h300, 64'h3002, 64'h0, 5'd9);
    exp_q.push_back(mkm(e, 64'h3002, 1'b0, 1'b1));
    issue(e, w);
    check("mis_latency", {63'h0, bus.out_valid}, 64'h1);
    @(negedge clk);
    check("mis_no_dreq", 64'(dreq_cycles - d0), 64'd0);

    // Flush in IDLE drops the incoming instruction
    bus.dataE    = mk(OP_ALU, 64'h380, 64'hDEAD, 64'h0, 5'd4);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    check("flush_idle_drop", {63'h0, bus.out_valid}, 64'h0);

    // Flush while BUSY: bus completes, result discarded, next op accepted at once
    e = mk(OP_LD, 64'h400, 64'h4000, 64'h0, 5'd5);
    issue(e, w);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    respond("ld_flush", 64'h4000, MSIZE8, 8'h00, 1'b0, 64'h0, 64'h5555_AAAA_5555_AAAA, 2);
    check("flush_busy_out_valid", {63'h0, bus.out_valid}, 64'h0);
    e = mk(OP_ALU, 64'h410, 64'h55, 64'h0, 5'd6);
    exp_q.push_back(mkm(e, 64'h55, 1'b1, 1'b0));
    issue(e, w);
    check("accept_after_flush", 64'(w), 64'd0);

    // Async reset mid-BUSY
    @(negedge clk);
    e = mk(OP_LW, 64'h500, 64'h5000, 64'h0, 5'd8);
    issue(e, w);
    check("pre_reset_busy", {63'h0, bus.dreq.valid}, 64'h1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_dreq", {63'h0, bus.dreq.valid}, 64'h0);
    check("async_rst_out", {63'h0, bus.out_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

    repeat (20) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage that consumes the EX-stage result bundle (execute_data_t) and performs loads and stores over the data bus (dbus request/response handshake).
- Produces memory_data_t for the writeback register.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Stalls the pipeline via in_ready while a bus transaction is outstanding.

Parameters:
ALIGN_CHECK, 1, when 1 misaligned accesses issue no bus request and set dataM.misalign; when 0 the address is sent unchecked.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  dataE holds a valid instruction
in_ready  output  1  stage accepts dataE this cycle
flush  input  1  synchronous kill of the current/pending instruction
dataE  input  execute_data_t  pc, instruction, result (address/ALU value), memdata (store data), ctl.op/memread/memwrite/regwrite, dst
dreq  output  dbus_req_t  valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
dresp  input  dbus_resp_t  addr_ok, data_ok, data[63:0]
out_valid  output  1  dataM valid
out_ready  input  1  writeback accepts dataM
dataM  output  memory_data_t  pc, instruction, result (load data or ALU value), ctl.regwrite, dst, misalign

Behaviour:
- Reset (reset==0, async): state=IDLE, out_valid=0, dreq.valid=0, dataM all-zero, kill flag=0.
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: dreq.valid=1. addr, size, strobe and data come from latched registers and stay stable until data_ok.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output register: out_valid clears on out_ready unless reloaded the same cycle.
- Accept in IDLE (in_valid && in_ready && !flush):
  - Non-memory op: dataM loaded next edge with result=dataE.result. Latency 1.
  - Misaligned access with ALIGN_CHECK=1: same 1-cycle path with misalign=1, regwrite=0, and no bus request.
  - Aligned memory op: latch the bundle, go to BUSY. dreq.valid is asserted from the next cycle (registered).
- Alignment rule: B any address; H addr[0]==0; W addr[1:0]==0; D addr[2:0]==0.
- Store encoding:
  - strobe = size mask shifted left by addr[2:0].
  - data = memdata replicated/shifted into byte lane addr[2:0].
  - SB/SH/SW/SD masks: 0x01/0x03/0x0F/0xFF.
- BUSY:
  - addr_ok is informational only.
  - On data_ok, next edge: state=IDLE, out_valid=1.
  - Load: result = dresp.data >> (8*addr[2:0]), then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD).
  - Store: result = 0, regwrite = 0.
- Minimum load/store latency: accept -> dreq.valid 1 cycle; data_ok -> out_valid 1 cycle.
- flush:
  - In IDLE: drops the incoming instruction.
  - In BUSY: the bus transaction still completes (valid is held until data_ok). The kill flag is set and the result is discarded, leaving out_valid=0.
  - flush also clears a pending out_valid.
- Simultaneous data_ok and flush: the result is discarded; the FSM returns to IDLE normally.
- data_ok while the output register is occupied cannot occur, because acceptance requires the output register to be free.
- Async reset mid-BUSY: dreq.valid drops immediately. The bus side must tolerate an abandoned request.

Decomposition:
- pipes package:
  - memory_data_t
  - mem_state_t enum (IDLE, BUSY)
- common package:
  - dbus_req_t, dbus_resp_t, msize_t
  - byte-mask constants
- One sub-module: mem_align (combinational). Computes strobe/wdata for stores and extract/extend for loads from op + addr[2:0].

Test Plan:
- ADD pass-through: result=0x1234, in_valid=1 -> next cycle out_valid=1, dataM.result=0x1234, dreq.valid never asserted.
- LB at addr 0x1003, memory word 0x0000_0000_8000_0000 (byte3=0x80), data_ok 3 cycles after valid -> dreq.size=byte, in_ready=0 throughout BUSY, dataM.result=0xFFFF_FFFF_FFFF_FF80; LBU gives 0x80.
- SH at addr 0x2002, memdata=0xBEEF -> dreq.strobe=0x0C, dreq.data[31:16]=0xBEEF, dataM.regwrite=0, addr/data stable until data_ok.
- LW at addr 0x3002 with ALIGN_CHECK=1 -> no dreq.valid, dataM.misalign=1 after 1 cycle.
- LD issued, flush asserted while BUSY -> dreq.valid held until data_ok, out_valid stays 0, next instruction accepted the cycle after return to IDLE.
- Reset deasserted→asserted (reset=0) during BUSY -> dreq.valid=0 and out_valid=0 asynchronously; after release, in_ready=1.
